gray_rx_nbits: RTL and testbench

//  Receive side of the N-bit Gray counter bus: samples an N-bit Gray code,

---
 rtl/gray_rx_nbits_pkg.sv | 26 ++
 rtl/gray_rx_nbits_gray2bin.sv | 19 +
 rtl/gray_rx_nbits.sv | 144 ++++++++++++++
 tb/tb_gray_rx_nbits.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_rx_nbits_pkg.sv
// Shared definitions for the Gray-code receiver.
//   - FSM state encodings (ACQUIRE / TRACK / FAULT)
//   - default parameter values
//   - gray_to_bin(): Gray-to-binary conversion on a zero-extended 32-bit word
package gray_rx_nbits_pkg;

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_TRACK   = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  localparam int DEF_N         = 4;
  localparam int DEF_ERR_LIMIT = 3;
  localparam int DEF_CNT_W     = 8;

  // Zero-extension leaves the unused upper bits at 0, so the result is
  // correct for any code width up to 32.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_rx_nbits_gray2bin.sv
// Combinational Gray-to-binary converter between stage 1 and stage 2.
// Ports:
//   gray_i  in   N  Gray-coded value
//   bin_o   out  N  binary equivalent
module gray_rx_nbits_gray2bin
  import gray_rx_nbits_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  logic [31:0] bin_full;

  assign bin_full = gray_to_bin(32'(gray_i));
  assign bin_o    = bin_full[N-1:0];

endmodule

// File: rtl/gray_rx_nbits.sv
// Receive side of an N-bit Gray counter bus. Captures the Gray code, converts
// it to binary one stage later and classifies each transition against the
// previous accepted sample (up / down / hold / error). Tracks lock and counts
// step errors.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   clk_en_i     sample enable, gray_i captured when 1
//   resync_i     force ACQUIRE, drop in-flight and same-cycle samples
//   gray_i       N-bit Gray code from the transmitter
//   bin_o        binary value of the last decoded sample
//   valid_o      one-cycle pulse, bin_o and step flags updated
//   step_up_o    with valid: sample = previous + 1 (mod 2^N)
//   step_dn_o    with valid: sample = previous - 1 (mod 2^N)
//   step_err_o   with valid: illegal jump
//   locked_o     1 while in TRACK
//   err_count_o  saturating total of step errors since reset
//
// state   | meaning
// ACQUIRE | waiting for first sample to load the reference
// TRACK   | classifying every sample against the previous one
// FAULT   | ERR_LIMIT consecutive errors; decode only, wait for resync
module gray_rx_nbits
  import gray_rx_nbits_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clk_en_i,
  input  logic             resync_i,
  input  logic [N-1:0]     gray_i,
  output logic [N-1:0]     bin_o,
  output logic             valid_o,
  output logic             step_up_o,
  output logic             step_dn_o,
  output logic             step_err_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] err_count_o
);

  logic             s1_vld_q, s1_vld_d;
  logic [N-1:0]     s1_gray_q, s1_gray_d;
  logic [N-1:0]     s1_bin;
  logic [N-1:0]     bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       consec_q, consec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     diff;
  logic [3:0]       consec_inc;

  gray_rx_nbits_gray2bin #(.N(N)) u_gray2bin (
    .gray_i (s1_gray_q),
    .bin_o  (s1_bin)
  );

  // bin_q doubles as the previous accepted sample; modular difference
  // gives wrap-around for free.
  assign diff       = s1_bin - bin_q;
  assign consec_inc = consec_q + 4'd1;

  always_comb begin
    s1_vld_d  = clk_en_i & ~resync_i;
    s1_gray_d = clk_en_i ? gray_i : s1_gray_q;
    bin_d     = bin_q;
    valid_d   = 1'b0;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    err_d     = 1'b0;
    state_d   = state_q;
    consec_d  = consec_q;
    cnt_d     = cnt_q;

    if (resync_i) begin
      state_d  = ST_ACQUIRE;
      consec_d = 4'd0;
    end else if (s1_vld_q) begin
      valid_d = 1'b1;
      bin_d   = s1_bin;
      case (state_q)
        ST_ACQUIRE: state_d = ST_TRACK;
        ST_TRACK: begin
          if (diff == N'(1)) begin
            up_d     = 1'b1;
            consec_d = 4'd0;
          end else if (diff == {N{1'b1}}) begin
            dn_d     = 1'b1;
            consec_d = 4'd0;
          end else if (diff != '0) begin
            // Any non-adjacent jump, including a single-bit flip that is not
            // +/-1, is an illegal transition.
            err_d    = 1'b1;
            consec_d = consec_inc;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (consec_inc == 4'(ERR_LIMIT)) state_d = ST_FAULT;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_gray_q <= '0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= ST_ACQUIRE;
      consec_q  <= 4'd0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_gray_q <= s1_gray_d;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
      state_q   <= state_d;
      consec_q  <= consec_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bin_o       = bin_q;
  assign valid_o     = valid_q;
  assign step_up_o   = up_q;
  assign step_dn_o   = dn_q;
  assign step_err_o  = err_q;
  assign locked_o    = (state_q == ST_TRACK);
  assign err_count_o = cnt_q;

endmodule

// File: tb/tb_gray_rx_nbits.sv
module tb_gray_rx_nbits;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clk_en_i = 1'b0;
  logic       resync_i = 1'b0;
  logic [3:0] gray_i = 4'd0;
  logic [3:0] bin_o;
  logic       valid_o, step_up_o, step_dn_o, step_err_o, locked_o;
  logic [7:0] err_count_o;

  gray_rx_nbits #(.N(4), .ERR_LIMIT(3), .CNT_W(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clk_en_i    (clk_en_i),
    .resync_i    (resync_i),
    .gray_i      (gray_i),
    .bin_o       (bin_o),
    .valid_o     (valid_o),
    .step_up_o   (step_up_o),
    .step_dn_o   (step_dn_o),
    .step_err_o  (step_err_o),
    .locked_o    (locked_o),
    .err_count_o (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [3:0] g;
    logic       en;
    logic       rs;
    logic [16:0] exp;  // {valid, up, dn, err, locked, bin[3:0], cnt[7:0]}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] g, input logic en, input logic rs,
                              input logic v, input logic u, input logic d,
                              input logic e, input logic l, input int b, input int c);
    vec_t r;
    r.g = g; r.en = en; r.rs = rs;
    r.exp = {v, u, d, e, l, 4'(b), 8'(c)};
    return r;
  endfunction

  function automatic logic [16:0] dut_vec();
    return {valid_o, step_up_o, step_dn_o, step_err_o, locked_o, bin_o, err_count_o};
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got v/u/d/e/l/bin/cnt=%b/%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%b/%0d/%0d",
                  nm, act[16], act[15], act[14], act[13], act[12], act[11:8], act[7:0],
                  exp[16], exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = acquiring, 1 = tracking, 2 = faulted
  int m_pend_v, m_pend_g;
  int m_mode, m_prev, m_consec, m_cnt;
  int m_vld, m_up, m_dn, m_er;

  function automatic int g2b(input int g);
    for (int v = 0; v < 16; v++) if ((v ^ (v >> 1)) == g) return v;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend_v = 0; m_pend_g = 0; m_mode = 0; m_prev = 0; m_consec = 0; m_cnt = 0;
    m_vld = 0; m_up = 0; m_dn = 0; m_er = 0;
  endtask

  task automatic model_step(input int g, input int en, input int rs);
    int b, d;
    m_vld = 0; m_up = 0; m_dn = 0; m_er = 0;
    if (rs != 0) begin
      m_mode = 0; m_consec = 0; m_pend_v = 0;
      return;
    end
    if (m_pend_v != 0) begin
      b = g2b(m_pend_g);
      m_vld = 1;
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        d = (b - m_prev + 16) % 16;
        if (d == 1) begin m_up = 1; m_consec = 0; end
        else if (d == 15) begin m_dn = 1; m_consec = 0; end
        else if (d != 0) begin
          m_er = 1;
          m_consec++;
          if (m_cnt < 255) m_cnt++;
          if (m_consec == 3) m_mode = 2;
        end
      end
      m_prev = b;
    end
    m_pend_v = en;
    if (en != 0) m_pend_g = g;
  endtask

  function automatic logic [16:0] model_vec();
    return {m_vld[0], m_up[0], m_dn[0], m_er[0], (m_mode == 1), 4'(m_prev), 8'(m_cnt)};
  endfunction

  // one clock: drive, advance model at the edge, compare 1 time unit later
  task automatic cyc(input logic [3:0] g, input logic en, input logic rs, input string nm);
    gray_i = g; clk_en_i = en; resync_i = rs;
    @(posedge clk_i);
    model_step(int'(g), int'(en), int'(rs));
    #1;
    if (nm != "") check(nm, dut_vec(), model_vec());
  endtask

  task automatic mid_reset(input string nm);
    #1;
    rst_ni = 1'b0;
    clk_en_i = ~clk_en_i;
    #1;
    check(nm, dut_vec(), 17'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  int drv_bin;
  int r;
  logic [3:0] g;

  initial begin
    model_reset();
    #3;
    check("reset_state", dut_vec(), 17'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // directed sequences: count, wrap, errors, fault, resync
    tbl.push_back(mk(4'b0000,1,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(4'b0001,1,0, 1,0,0,0,1, 0,0));
    tbl.push_back(mk(4'b0011,1,0, 1,1,0,0,1, 1,0));
    tbl.push_back(mk(4'b0010,1,0, 1,1,0,0,1, 2,0));
    tbl.push_back(mk(4'b0000,0,0, 1,1,0,0,1, 3,0));
    tbl.push_back(mk(4'b0000,0,0, 0,0,0,0,1, 3,0));
    tbl.push_back(mk(4'b0000,0,1, 0,0,0,0,0, 3,0));
    tbl.push_back(mk(4'b1001,1,0, 0,0,0,0,0, 3,0));
    tbl.push_back(mk(4'b1000,1,0, 1,0,0,0,1, 14,0));
    tbl.push_back(mk(4'b0000,1,0, 1,1,0,0,1, 15,0));
    tbl.push_back(mk(4'b1000,1,0, 1,1,0,0,1, 0,0));
    tbl.push_back(mk(4'b0000,0,0, 1,0,1,0,1, 15,0));
    tbl.push_back(mk(4'b0000,0,1, 0,0,0,0,0, 15,0));
    tbl.push_back(mk(4'b0001,1,0, 0,0,0,0,0, 15,0));
    tbl.push_back(mk(4'b0010,1,0, 1,0,0,0,1, 1,0));
    tbl.push_back(mk(4'b0110,1,0, 1,0,0,1,1, 3,1));
    tbl.push_back(mk(4'b0000,0,0, 1,1,0,0,1, 4,1));
    tbl.push_back(mk(4'b0000,0,0, 0,0,0,0,1, 4,1));
    tbl.push_back(mk(4'b0000,0,1, 0,0,0,0,0, 4,1));
    tbl.push_back(mk(4'b0000,1,0, 0,0,0,0,0, 4,1));
    tbl.push_back(mk(4'b0011,1,0, 1,0,0,0,1, 0,1));
    tbl.push_back(mk(4'b0101,1,0, 1,0,0,1,1, 2,2));
    tbl.push_back(mk(4'b1010,1,0, 1,0,0,1,1, 6,3));
    tbl.push_back(mk(4'b1011,1,0, 1,0,0,1,0, 12,4));
    tbl.push_back(mk(4'b0000,0,0, 1,0,0,0,0, 13,4));
    tbl.push_back(mk(4'b0000,1,1, 0,0,0,0,0, 13,4));
    tbl.push_back(mk(4'b0001,1,0, 0,0,0,0,0, 13,4));
    tbl.push_back(mk(4'b0000,0,0, 1,0,0,0,1, 1,4));
    tbl.push_back(mk(4'b0011,1,0, 0,0,0,0,1, 1,4));
    tbl.push_back(mk(4'b0010,1,1, 0,0,0,0,0, 1,4));
    tbl.push_back(mk(4'b0000,0,0, 0,0,0,0,0, 1,4));

    foreach (tbl[i]) begin
      cyc(tbl[i].g, tbl[i].en, tbl[i].rs, "");
      check($sformatf("row%0d", i), dut_vec(), tbl[i].exp);
    end

    // mid-stream reset, then first sample must act as acquire
    cyc(4'b0001, 1'b1, 1'b0, "pre_rst");
    mid_reset("rst_mid_directed");
    cyc(4'b0110, 1'b1, 1'b0, "post_rst0");
    check("post_rst_acq", dut_vec(), 17'd0);
    cyc(4'b0111, 1'b1, 1'b0, "post_rst1");
    check("post_rst_lock", dut_vec(), {1'b1, 4'b0001, 4'd4, 8'd0});

    // randomized traffic against the model
    drv_bin = 0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       drv_bin = (drv_bin + 1) % 16;
      else if (r < 6)  drv_bin = (drv_bin + 15) % 16;
      else if (r < 7)  drv_bin = drv_bin;
      else             drv_bin = $urandom_range(0, 15);
      g = 4'(drv_bin ^ (drv_bin >> 1));
      cyc(g, 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 39) == 0),
          $sformatf("rnd%0d", k));
      if ($urandom_range(0, 299) == 0) mid_reset($sformatf("rnd_rst%0d", k));
    end

    // err_count saturation: 3 errors per acquire round, 90 rounds
    mid_reset("rst_before_sat");
    for (int k = 0; k < 90; k++) begin
      cyc(4'd0, 1'b0, 1'b1, $sformatf("sat_rs%0d", k));
      for (int j = 0; j < 4; j++) begin
        drv_bin = 5 * j;
        cyc(4'(drv_bin ^ (drv_bin >> 1)), 1'b1, 1'b0, $sformatf("sat%0d_%0d", k, j));
      end
      cyc(4'd0, 1'b0, 1'b0, $sformatf("sat_tail%0d", k));
    end
    n_tot++;
    if (err_count_o === 8'hFF) n_pass++;
    else $display("FAIL err_count_saturation: got %0d expected 255", err_count_o);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
